// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the RAM arbiter between the CPU bus and
// the video fetch port.
package mem_arbiter_pkg;

    // Owner of the RAM port in the current cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_VID  = 2'd2
    } state_t;

    // Encoding of the most recent grant, used for round-robin fairness.
    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_VID = 1'b1;

    // Longest run of lost arbitration rounds a pending CPU access tolerates.
    localparam int DEFAULT_MAX_CPU_WAIT = 15;

endpackage

// File: rtl/mem_arb_cpu_slot.sv
// CPU side of the arbiter: captures read/write requests, tracks pending and
// in-flight reads, registers returned read data and produces the busy flags.
// Everything toward the RAM comes from registers, so no cpu_* input reaches
// ram_* combinationally.
module mem_arb_cpu_slot
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [DATA_W/8-1:0]   cpu_wmask,
    input  logic                  cpu_rstrb,
    input  logic                  grant,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  cpu_pend,
    output logic [ADDR_W-1:0]     acc_addr,
    output logic [DATA_W-1:0]     acc_wdata,
    output logic [DATA_W/8-1:0]   acc_we,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_rbusy,
    output logic                  cpu_wbusy
);

    localparam int LANES = DATA_W / 8;

    logic              rd_pend;
    logic              wr_pend;
    logic              rd_inflight;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [LANES-1:0]  wr_mask;
    logic              write_req;
    logic              svc_write;
    logic              svc_read;

    // A pending write always goes out before a pending read.
    assign write_req = |cpu_wmask;
    assign svc_write = grant && wr_pend;
    assign svc_read  = grant && !wr_pend;

    // Control state: a new capture wins over the clear from a grant in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_pend     <= 1'b0;
            rd_pend     <= 1'b0;
            rd_inflight <= 1'b0;
            cpu_rdata   <= '0;
        end else begin
            if (write_req) begin
                wr_pend <= 1'b1;
            end else if (svc_write) begin
                wr_pend <= 1'b0;
            end
            if (cpu_rstrb) begin
                rd_pend <= 1'b1;
            end else if (svc_read) begin
                rd_pend <= 1'b0;
            end
            rd_inflight <= svc_read;
            if (rd_inflight) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

    // Request payload: only meaningful while the matching pending flag is set.
    always_ff @(posedge clk) begin
        if (cpu_rstrb) begin
            rd_addr <= cpu_addr;
        end
        if (write_req) begin
            wr_addr <= cpu_addr;
            wr_data <= cpu_wdata;
            wr_mask <= cpu_wmask;
        end
    end

    assign cpu_pend  = rd_pend | wr_pend;
    assign acc_addr  = wr_pend ? wr_addr : rd_addr;
    assign acc_wdata = wr_data;
    assign acc_we    = wr_pend ? wr_mask : '0;
    assign cpu_wbusy = wr_pend;
    assign cpu_rbusy = rd_pend | rd_inflight;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the FemtoRV32 bus and the
// video fetch port. Video wins while urgent, a bounded wait counter forces a
// CPU grant after MAX_CPU_WAIT lost rounds, otherwise grants alternate.
// Optional stall statistics are built when MEM_ARBITER_STATS_EN is defined;
// without it cpu_stall_cnt and vid_stall_cnt are constant zero.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int MAX_CPU_WAIT = DEFAULT_MAX_CPU_WAIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [DATA_W/8-1:0]   cpu_wmask,
    input  logic                  cpu_rstrb,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_rbusy,
    output logic                  cpu_wbusy,
    input  logic                  vid_req,
    input  logic                  vid_urgent,
    input  logic [ADDR_W-1:0]     vid_addr,
    output logic                  vid_ack,
    output logic                  vid_valid,
    output logic [DATA_W-1:0]     vid_rdata,
    output logic                  ram_en,
    output logic [DATA_W/8-1:0]   ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic [15:0]           cpu_stall_cnt,
    output logic [15:0]           vid_stall_cnt
);

    localparam int                 WAIT_W     = $clog2(MAX_CPU_WAIT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MAX_CPU_WAIT);

    state_t                 state_q;
    state_t                 state_d;
    logic                   last_grant;
    logic [WAIT_W-1:0]      wait_cnt;
    logic                   grant_cpu;
    logic                   cpu_pend;
    logic [ADDR_W-1:0]      acc_addr;
    logic [DATA_W-1:0]      acc_wdata;
    logic [DATA_W/8-1:0]    acc_we;

    function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
        return (v == WAIT_LIMIT) ? v : v + WAIT_W'(1);
    endfunction

    mem_arb_cpu_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cpu_slot (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wmask (cpu_wmask),
        .cpu_rstrb (cpu_rstrb),
        .grant     (grant_cpu),
        .ram_rdata (ram_rdata),
        .cpu_pend  (cpu_pend),
        .acc_addr  (acc_addr),
        .acc_wdata (acc_wdata),
        .acc_we    (acc_we),
        .cpu_rdata (cpu_rdata),
        .cpu_rbusy (cpu_rbusy),
        .cpu_wbusy (cpu_wbusy)
    );

    // Grant decision for this cycle and the RAM port mux driven from it.
    always_comb begin
        state_d   = S_IDLE;
        grant_cpu = 1'b0;
        vid_ack   = 1'b0;
        ram_en    = 1'b0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!reset) begin
            if (cpu_pend && (wait_cnt == WAIT_LIMIT)) begin
                state_d = S_CPU;
            end else if (vid_req && vid_urgent) begin
                state_d = S_VID;
            end else if (cpu_pend && vid_req) begin
                state_d = (last_grant == GRANT_VID) ? S_CPU : S_VID;
            end else if (cpu_pend) begin
                state_d = S_CPU;
            end else if (vid_req) begin
                state_d = S_VID;
            end
        end
        case (state_d)
            S_CPU: begin
                grant_cpu = 1'b1;
                ram_en    = 1'b1;
                ram_we    = acc_we;
                ram_addr  = acc_addr;
                ram_wdata = acc_wdata;
            end
            S_VID: begin
                vid_ack  = 1'b1;
                ram_en   = 1'b1;
                ram_addr = vid_addr;
            end
            default: begin
            end
        endcase
    end

    // Owner register; a video owner last cycle means RAM data is for video now.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fairness memory and bounded-wait counter for the CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GRANT_VID;
            wait_cnt   <= '0;
        end else begin
            if (state_d == S_CPU) begin
                last_grant <= GRANT_CPU;
            end else if (state_d == S_VID) begin
                last_grant <= GRANT_VID;
            end
            if (grant_cpu) begin
                wait_cnt <= '0;
            end else if (cpu_pend) begin
                wait_cnt <= wait_inc(wait_cnt);
            end
        end
    end

    // A fetch cut short by reset never reports valid data.
    assign vid_valid = (state_q == S_VID) && !reset;
    assign vid_rdata = ram_rdata;

`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] cpu_stall_q;
    logic [15:0] vid_stall_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating counts of cycles each requester waited without a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_stall_q <= 16'd0;
            vid_stall_q <= 16'd0;
        end else begin
            if (cpu_pend && !grant_cpu) begin
                cpu_stall_q <= sat_inc16(cpu_stall_q);
            end
            if (vid_req && !vid_ack) begin
                vid_stall_q <= sat_inc16(vid_stall_q);
            end
        end
    end

    assign cpu_stall_cnt = cpu_stall_q;
    assign vid_stall_cnt = vid_stall_q;
`else
    assign cpu_stall_cnt = 16'd0;
    assign vid_stall_cnt = 16'd0;
`endif

endmodule
